// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer driving a memory buffer register
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           request one fetch (honoured in IDLE only)
//   run             continuous fetch; sampled when VALID is left
//   branch_en       load pc from branch_addr (direct in IDLE/CAPT, pending otherwise)
//   branch_addr     branch target
//   mbr_data        data_out of the memory buffer register
//   ir_ready        consumer accepts ir
//   pointer         registered memory address (MAR)
//   dram_in         buffer register capture strobe (LOAD)
//   mbr_out         buffer register drive strobe (DRIVE)
//   ir, ir_valid    instruction register and its valid flag
//   pc              program counter
//   busy            high whenever the FSM is not IDLE
module fetch_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       run,
    input  logic       branch_en,
    input  logic [3:0] branch_addr,
    input  logic [7:0] mbr_data,
    input  logic       ir_ready,
    output logic [3:0] pointer,
    output logic       dram_in,
    output logic       mbr_out,
    output logic [7:0] ir,
    output logic       ir_valid,
    output logic [3:0] pc,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WAIT  = 3'd2,
        S_LOAD  = 3'd3,
        S_DRIVE = 3'd4,
        S_CAPT  = 3'd5,
        S_VALID = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] pointer_q, pointer_d;
    logic [7:0] ir_q, ir_d;
    logic       ir_valid_q, ir_valid_d;
    logic       pend_valid_q, pend_valid_d;
    logic [3:0] pend_addr_q, pend_addr_d;
    logic       dram_in_q, dram_in_d;
    logic       mbr_out_q, mbr_out_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pointer_d    = pointer_q;
        ir_d         = ir_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;

        // A branch seen mid-fetch is remembered (latest wins) and applied
        // when the current instruction is captured.
        if (branch_en && state_q != S_IDLE && state_q != S_CAPT) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = branch_addr;
        end

        case (state_q)
            S_IDLE: begin
                // pc is loaded here so ADDR naturally fetches from the target
                if (branch_en) pc_d = branch_addr;
                if (start) state_d = S_ADDR;
            end
            S_ADDR: begin
                pointer_d = pc_q;
                state_d   = S_WAIT;
            end
            S_WAIT:  state_d = S_LOAD;
            S_LOAD:  state_d = S_DRIVE;
            S_DRIVE: state_d = S_CAPT;
            S_CAPT: begin
                ir_d = mbr_data;
                // Same-cycle branch beats a pending one, which beats pc+1.
                if (branch_en)         pc_d = branch_addr;
                else if (pend_valid_q) pc_d = pend_addr_q;
                else                   pc_d = pc_q + 4'd1;
                pend_valid_d = 1'b0;
                state_d      = S_VALID;
            end
            S_VALID: begin
                if (ir_ready) state_d = run ? S_ADDR : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        dram_in_d  = (state_d == S_LOAD);
        mbr_out_d  = (state_d == S_DRIVE);
        ir_valid_d = (state_d == S_VALID);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= 4'd0;
            pointer_q    <= 4'd0;
            ir_q         <= 8'd0;
            ir_valid_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 4'd0;
            dram_in_q    <= 1'b0;
            mbr_out_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pointer_q    <= pointer_d;
            ir_q         <= ir_d;
            ir_valid_q   <= ir_valid_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            dram_in_q    <= dram_in_d;
            mbr_out_q    <= mbr_out_d;
            busy_q       <= busy_d;
        end
    end

    assign pointer  = pointer_q;
    assign dram_in  = dram_in_q;
    assign mbr_out  = mbr_out_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign pc       = pc_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst, start, run, branch_en, ir_ready;
    logic [3:0] branch_addr;
    logic [7:0] mbr_data;
    logic [3:0] pointer, pc;
    logic       dram_in, mbr_out, ir_valid, busy;
    logic [7:0] ir;

    fetch_unit dut (
        .clk(clk), .rst(rst), .start(start), .run(run),
        .branch_en(branch_en), .branch_addr(branch_addr),
        .mbr_data(mbr_data), .ir_ready(ir_ready),
        .pointer(pointer), .dram_in(dram_in), .mbr_out(mbr_out),
        .ir(ir), .ir_valid(ir_valid), .pc(pc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory buffer register model: capture on dram_in, drive on mbr_out.
    logic [7:0] mem [16];
    logic [7:0] mbr_buf = 8'd0;
    always @(posedge clk) begin
        if (dram_in) mbr_buf <= mem[pointer];
        if (mbr_out) mbr_data <= mbr_buf;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] ir;
        logic [3:0] pc;
        logic [3:0] ptr;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int dram_pulses = 0;
    logic prev_valid = 1'b0;
    logic prev_dram = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per fresh ir_valid, checks strobe exclusivity.
    always @(negedge clk) begin
        exp_t e;
        chk("strobe_exclusive", {31'd0, dram_in & mbr_out}, 32'd0);
        if (dram_in && !prev_dram) dram_pulses++;
        prev_dram = dram_in;
        if (ir_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_ir_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ir", {24'd0, ir}, {24'd0, e.ir});
                chk("pc", {28'd0, pc}, {28'd0, e.pc});
                chk("pointer", {28'd0, pointer}, {28'd0, e.ptr});
                chk("latency", cyc, e.cyc);
            end
        end
        prev_valid = ir_valid;
    end

    // Pulse start (optionally with a branch); returns in ADDR with base = start edge.
    task automatic start_fetch(input logic [7:0] eir, input logic [3:0] epc,
                               input logic [3:0] eptr, input logic br,
                               input logic [3:0] baddr, output int base);
        exp_t e;
        @(negedge clk);
        start = 1'b1; branch_en = br; branch_addr = baddr;
        @(negedge clk);
        start = 1'b0; branch_en = 1'b0;
        base = cyc;
        e.ir = eir; e.pc = epc; e.ptr = eptr; e.cyc = base + 5;
        sb.push_back(e);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!ir_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ir_valid) chk("ir_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic accept(input logic run_v);
        ir_ready = 1'b1; run = run_v;
        @(negedge clk);
        ir_ready = 1'b0; run = 1'b0;
    endtask

    task automatic branch_idle(input logic [3:0] a);
        @(negedge clk);
        branch_en = 1'b1; branch_addr = a;
        @(negedge clk);
        branch_en = 1'b0;
    endtask

    initial begin
        int base;
        exp_t e;
        rst = 1'b1; start = 1'b1; run = 1'b0; branch_en = 1'b1;
        branch_addr = 4'd6; ir_ready = 1'b0; mbr_data = 8'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        repeat (2) @(negedge clk);
        start = 1'b0; branch_en = 1'b0;
        rst = 1'b0;
        chk("rst_pc", {28'd0, pc}, 32'd0);
        chk("rst_pointer", {28'd0, pointer}, 32'd0);
        chk("rst_ir", {24'd0, ir}, 32'd0);
        chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Single fetch of mem[0]
        mem[0] = 8'hA5;
        start_fetch(8'hA5, 4'd1, 4'd0, 1'b0, 4'd0, base);
        chk("busy_in_addr", {31'd0, busy}, 32'd1);
        wait_valid();
        accept(1'b0);
        mem[0] = 8'h10;

        // Continuous run from pc=14 across the wrap
        branch_idle(4'd14);
        chk("idle_branch_pc", {28'd0, pc}, 32'd14);
        chk("idle_branch_busy", {31'd0, busy}, 32'd0);
        ir_ready = 1'b1; run = 1'b1;
        start_fetch(8'h1E, 4'd15, 4'd14, 1'b0, 4'd0, base);
        e.ir = 8'h1F; e.pc = 4'd0; e.ptr = 4'd15; e.cyc = base + 11; sb.push_back(e);
        e.ir = 8'h10; e.pc = 4'd1; e.ptr = 4'd0;  e.cyc = base + 17; sb.push_back(e);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ir_valid && pc == 4'd1) begin
                run = 1'b0;
                break;
            end
        end
        @(negedge clk);
        ir_ready = 1'b0;
        chk("run_stop_busy", {31'd0, busy}, 32'd0);

        // Consumer stalls for 4 cycles in VALID
        start_fetch(8'h11, 4'd2, 4'd1, 1'b0, 4'd0, base);
        wait_valid();
        for (int i = 0; i < 4; i++) begin
            chk("hold_ir", {24'd0, ir}, 32'h11);
            chk("hold_valid", {31'd0, ir_valid}, 32'd1);
            chk("hold_strobes", {30'd0, dram_in, mbr_out}, 32'd0);
            chk("hold_pc", {28'd0, pc}, 32'd2);
            @(negedge clk);
        end
        accept(1'b0);
        chk("after_accept_valid", {31'd0, ir_valid}, 32'd0);
        chk("after_accept_busy", {31'd0, busy}, 32'd0);

        // Branch during WAIT of a fetch from pc=3
        branch_idle(4'd3);
        start_fetch(8'h13, 4'd9, 4'd3, 1'b0, 4'd0, base);
        @(negedge clk);
        branch_en = 1'b1; branch_addr = 4'd9;
        @(negedge clk);
        branch_en = 1'b0;
        wait_valid();
        accept(1'b0);
        start_fetch(8'h19, 4'd10, 4'd9, 1'b0, 4'd0, base);
        wait_valid();
        accept(1'b0);

        // Branch in CAPT overrides an earlier pending branch
        branch_idle(4'd8);
        start_fetch(8'h18, 4'd2, 4'd8, 1'b0, 4'd0, base);
        @(negedge clk);
        branch_en = 1'b1; branch_addr = 4'd5;
        @(negedge clk);
        branch_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        branch_en = 1'b1; branch_addr = 4'd2;
        @(negedge clk);
        branch_en = 1'b0;
        wait_valid();
        accept(1'b0);

        // Reset in LOAD aborts the fetch (no expectation pushed)
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("load_dram_in", {31'd0, dram_in}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_pc", {28'd0, pc}, 32'd0);
        chk("abort_ir", {24'd0, ir}, 32'd0);
        chk("abort_valid", {31'd0, ir_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_dram_in", {31'd0, dram_in}, 32'd0);
        repeat (8) @(negedge clk);

        // start and branch_en together in IDLE
        start_fetch(8'h17, 4'd8, 4'd7, 1'b1, 4'd7, base);
        wait_valid();
        accept(1'b0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        chk("dram_pulse_count", dram_pulses, 32'd10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
